// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and lane helpers.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned F3_WIDTH = 3;

    localparam logic [F3_WIDTH-1:0] F3_B  = 3'd0;
    localparam logic [F3_WIDTH-1:0] F3_H  = 3'd1;
    localparam logic [F3_WIDTH-1:0] F3_W  = 3'd2;
    localparam logic [F3_WIDTH-1:0] F3_BU = 3'd4;
    localparam logic [F3_WIDTH-1:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_STORE    = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_e;

    function automatic logic [7:0] get_byte(input logic [XLEN-1:0] w, input logic [1:0] lane);
        get_byte = w[{lane, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] get_half(input logic [XLEN-1:0] w, input logic hi);
        get_half = hi ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [XLEN-1:0] put_byte(input logic [XLEN-1:0] w, input logic [1:0] lane,
                                                 input logic [7:0] b);
        logic [XLEN-1:0] r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        put_byte = r;
    endfunction

    function automatic logic [XLEN-1:0] put_half(input logic [XLEN-1:0] w, input logic hi,
                                                 input logic [15:0] h);
        put_half = hi ? {h, w[15:0]} : {w[31:16], h};
    endfunction

    function automatic logic op_valid(input logic store, input logic [F3_WIDTH-1:0] f3);
        if (store) op_valid = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else       op_valid = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                              (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [F3_WIDTH-1:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: misaligned = lo[0];
            F3_W:        misaligned = (lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input logic [F3_WIDTH-1:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: align_lo = {lo[1], 1'b0};
            F3_W:        align_lo = 2'b00;
            default:     align_lo = lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load byte/half extract with extension, store lane merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [F3_WIDTH-1:0] funct3,
    input  logic [1:0]          addr_lo,
    input  logic [XLEN-1:0]     rdata,
    input  logic [XLEN-1:0]     wdata,
    input  logic [XLEN-1:0]     merge_buf,
    output logic [XLEN-1:0]     load_data_c,
    output logic [XLEN-1:0]     store_data_c
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte    = get_byte(rdata, addr_lo);
        sel_half    = get_half(rdata, addr_lo[1]);
        load_data_c = rdata;
        case (funct3)
            F3_B:    load_data_c = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data_c = {24'd0, sel_byte};
            F3_H:    load_data_c = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data_c = {16'd0, sel_half};
            default: load_data_c = rdata;
        endcase
    end

    always_comb begin
        store_data_c = wdata;
        case (funct3)
            F3_B:    store_data_c = put_byte(merge_buf, addr_lo, wdata[7:0]);
            F3_H:    store_data_c = put_half(merge_buf, addr_lo[1], wdata[15:0]);
            default: store_data_c = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one outstanding load/store, read-modify-write for SB/SH.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit ALIGN_CHECK  = 1'b1,
    parameter bit ERR_ON_BADOP = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [F3_WIDTH-1:0] req_funct3,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_error,
    output logic [XLEN-1:0]     mem_access_addr,
    output logic [XLEN-1:0]     mem_in,
    output logic                mem_write_en,
    output logic                mem_read_en,
    input  logic [XLEN-1:0]     mem_out
);

    lsu_state_e          state_q, state_d;
    logic [F3_WIDTH-1:0] funct3_q, funct3_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     buf_q, buf_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic                resp_error_q, resp_error_d;

    logic                op_ok_c;
    logic [F3_WIDTH-1:0] f3_eff_c;
    logic                acc_err_c;
    logic [XLEN-1:0]     load_data_c;
    logic [XLEN-1:0]     store_data_c;
    logic                access_c;

    // Undefined funct3 either errors or degrades to a word access.
    always_comb begin
        op_ok_c   = op_valid(req_store, req_funct3);
        f3_eff_c  = op_ok_c ? req_funct3 : F3_W;
        acc_err_c = (ERR_ON_BADOP && !op_ok_c) ||
                    (ALIGN_CHECK && misaligned(f3_eff_c, req_addr[1:0]));
    end

    lsu_align u_align (
        .funct3       (funct3_q),
        .addr_lo      (addr_q[1:0]),
        .rdata        (mem_out),
        .wdata        (wdata_q),
        .merge_buf    (buf_q),
        .load_data_c  (load_data_c),
        .store_data_c (store_data_c)
    );

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    funct3_d     = f3_eff_c;
                    addr_d       = {req_addr[31:2], align_lo(f3_eff_c, req_addr[1:0])};
                    wdata_d      = req_wdata;
                    resp_rdata_d = '0;
                    resp_error_d = acc_err_c;
                    if (acc_err_c)             state_d = ST_RESP;
                    else if (!req_store)       state_d = ST_LOAD;
                    else if (f3_eff_c == F3_W) state_d = ST_STORE;
                    else                       state_d = ST_RMW_READ;
                end
            end
            ST_LOAD: begin
                resp_rdata_d = load_data_c;
                state_d      = ST_RESP;
            end
            ST_RMW_READ: begin
                buf_d   = mem_out;
                state_d = ST_STORE;
            end
            ST_STORE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    // Strobes and bus decode straight from the state register.
    assign req_ready       = (state_q == ST_IDLE);
    assign resp_valid      = (state_q == ST_RESP);
    assign resp_rdata      = resp_rdata_q;
    assign resp_error      = resp_error_q;
    assign mem_read_en     = (state_q == ST_LOAD) || (state_q == ST_RMW_READ);
    assign mem_write_en    = (state_q == ST_STORE);
    assign access_c        = mem_read_en || mem_write_en;
    assign mem_access_addr = access_c ? {addr_q[31:2], 2'b00} : '0;
    assign mem_in          = mem_write_en ? store_data_c : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small combinational-read word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_in;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_out;

    logic [31:0] mem [0:15];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          reads;
        int          writes;
        logic [31:0] waddr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;

    load_store_unit #(.ALIGN_CHECK(1'b1), .ERR_ON_BADOP(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_error      (resp_error),
        .mem_access_addr (mem_access_addr),
        .mem_in          (mem_in),
        .mem_write_en    (mem_write_en),
        .mem_read_en     (mem_read_en),
        .mem_out         (mem_out)
    );

    always #5 clk = ~clk;

    assign mem_out = mem[mem_access_addr[5:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write_en) mem[mem_access_addr[5:2]] <= mem_in;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: bus sanity every cycle, response compared against scoreboard head.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read_en)  rd_cnt++;
            if (mem_write_en) wr_cnt++;
            if ((mem_read_en || mem_write_en) && sb.size() > 0)
                chk("mem_addr", mem_access_addr, sb[0].waddr);
            if (!mem_read_en && !mem_write_en)
                chk("idle_bus", mem_access_addr | mem_in, 32'h0);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp_rdata",  resp_rdata, e.rdata);
                    chk("resp_error",  32'(resp_error), 32'(e.err));
                    chk("resp_cycle",  32'(cyc), 32'(e.cyc));
                    chk("read_count",  32'(rd_cnt), 32'(e.reads));
                    chk("write_count", 32'(wr_cnt), 32'(e.writes));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat, input int nr, input int nw, input bit hold);
        exp_t e;
        int   n;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'h0, 32'h1);
        end else begin
            e.rdata  = er;
            e.err    = ee;
            e.cyc    = cyc + lat;
            e.reads  = nr;
            e.writes = nw;
            e.waddr  = {a[31:2], 2'b00};
            @(posedge clk);
            sb.push_back(e);
            @(negedge clk);
            chk("ready_low_after_accept", 32'(req_ready), 32'h0);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h8899AABB;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_store = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        #12;
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_error", 32'(resp_error), 32'h0);
        chk("rst_mem_bus", mem_access_addr | mem_in, 32'h0);
        chk("rst_strobes", 32'({mem_read_en, mem_write_en}), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Loads from word[1]
        issue(1'b0, 3'd2, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0, 1'b0);
        issue(1'b0, 3'd0, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0, 1'b0);
        issue(1'b0, 3'd4, 32'h5, 32'h0, 32'h000000AA, 1'b0, 2, 1, 0, 1'b0);
        issue(1'b0, 3'd1, 32'h6, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0, 1'b0);
        issue(1'b0, 3'd5, 32'h4, 32'h0, 32'h0000AABB, 1'b0, 2, 1, 0, 1'b0);
        // SB read-modify-write, then read back
        issue(1'b1, 3'd0, 32'h6, 32'h12345677, 32'h0, 1'b0, 3, 1, 1, 1'b0);
        issue(1'b0, 3'd2, 32'h4, 32'h0, 32'h8877AABB, 1'b0, 2, 1, 0, 1'b0);
        // Misaligned SH errors without bus activity; next LW is normal
        issue(1'b1, 3'd1, 32'h3, 32'hFFFF, 32'h0, 1'b1, 1, 0, 0, 1'b0);
        issue(1'b0, 3'd2, 32'h4, 32'h0, 32'h8877AABB, 1'b0, 2, 1, 0, 1'b0);
        // Back-to-back with req_valid held high throughout
        issue(1'b1, 3'd1, 32'h4, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 1, 1'b1);
        issue(1'b1, 3'd2, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0, 2, 0, 1, 1'b1);
        issue(1'b0, 3'd2, 32'h8, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0, 1'b1);
        issue(1'b0, 3'd0, 32'h7, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1, 0, 1'b1);
        issue(1'b0, 3'd4, 32'h4, 32'h0, 32'h000000EF, 1'b0, 2, 1, 0, 1'b1);
        issue(1'b0, 3'd3, 32'h4, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b1);
        issue(1'b1, 3'd4, 32'h4, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b1);
        issue(1'b1, 3'd2, 32'hA, 32'h1, 32'h0, 1'b1, 1, 0, 0, 1'b1);
        issue(1'b0, 3'd5, 32'h9, 32'h0, 32'h0, 1'b1, 1, 0, 0, 1'b1);
        issue(1'b0, 3'd1, 32'hE, 32'h0, 32'h00000000, 1'b0, 2, 1, 0, 1'b0);
        drain();
        chk("mem_word1_after_sh", mem[1], 32'h8877BEEF);
        chk("mem_word2_after_sw", mem[2], 32'hCAFEF00D);

        // Reset during RMW_READ of an SB aborts without a write
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h6;
        req_wdata  = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_read_strobe", 32'({mem_read_en, mem_write_en}), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_strobes", 32'({mem_read_en, mem_write_en, resp_valid}), 32'h0);
        chk("async_rst_bus", mem_access_addr | mem_in, 32'h0);
        chk("async_rst_ready", 32'(req_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("word1_unchanged", mem[1], 32'h8877BEEF);
        chk("idle_after_reset", 32'(req_ready), 32'h1);
        issue(1'b0, 3'd2, 32'h4, 32'h0, 32'h8877BEEF, 1'b0, 2, 1, 0, 1'b0);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
